// File: rtl/fetch_buffer_if.sv
// Fetch front-end bundle: instruction-memory request/response, redirect, and decode handshake.
// The master modport is the fetch buffer; the slave modport is its environment.
interface fetch_buffer_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic              imem_req_o;
    logic [AWIDTH-1:0] imem_addr_o;
    logic [DWIDTH-1:0] imem_data_i;
    logic              redirect_i;
    logic [AWIDTH-1:0] redirect_pc_i;
    logic              valid_o;
    logic              ready_i;
    logic [AWIDTH-1:0] pc_o;
    logic [DWIDTH-1:0] insn_o;
    logic [CntW-1:0]   count_o;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_data_i,
        input  redirect_i,
        input  redirect_pc_i,
        output valid_o,
        input  ready_i,
        output pc_o,
        output insn_o,
        output count_o
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_data_i,
        output redirect_i,
        output redirect_pc_i,
        input  valid_o,
        output ready_i,
        input  pc_o,
        input  insn_o,
        input  count_o
    );
endinterface

// File: rtl/fetch_buffer.sv
// Decoupled instruction fetch: owns the PC, issues one-cycle-latency imem reads and queues
// {pc, insn} pairs for decode. A redirect flushes the queue and squashes the in-flight read.
module fetch_buffer #(
    parameter int unsigned       AWIDTH   = 32,
    parameter int unsigned       DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000),
    parameter int unsigned       DEPTH    = 4
) (
    input logic     clk,
    input logic     rst,
    fetch_buffer_if.master bus
);
    localparam int unsigned   PtrW     = $clog2(DEPTH);
    localparam int unsigned   CntW     = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [AWIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    logic [AWIDTH-1:0] pc_mem   [DEPTH];
    logic [DWIDTH-1:0] insn_mem [DEPTH];

    logic [CntW-1:0] credit;
    logic            issue;
    logic            push;
    logic            pop;
    logic            not_empty;
    logic            valid;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^bus.redirect_pc_i[1:0];

    // Outstanding read reserves a slot; the pop in this cycle is deliberately not credited,
    // which keeps the request path independent of ready_i.
    assign credit    = count_q + CntW'(inflight_q);
    assign issue     = rst && !bus.redirect_i && (credit < DepthCnt);
    assign push      = inflight_q && !bus.redirect_i;
    assign not_empty = (count_q != '0);
    assign valid     = not_empty && !bus.redirect_i;
    assign pop       = valid && bus.ready_i;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (bus.redirect_i) begin
            pc_d     = {bus.redirect_pc_i[AWIDTH-1:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + AWIDTH'(4);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= BASEADDR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Payload storage needs no reset: it is only observed while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
            insn_mem[wr_ptr_q] <= bus.imem_data_i;
        end
    end

    assign bus.imem_req_o  = issue;
    assign bus.imem_addr_o = pc_q;
    assign bus.valid_o     = valid;
    assign bus.pc_o        = not_empty ? pc_mem[rd_ptr_q] : '0;
    assign bus.insn_o      = not_empty ? insn_mem[rd_ptr_q] : '0;
    assign bus.count_o     = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        push |-> (count_q != DepthCnt));

endmodule
